panel_scanner: RTL and testbench
================================

# panel_scanner

Read side of the double-buffered frame memory that the pattern writers (e.g. the dimmer) fill. Scans a 32-row × 2^COLS-column RGB frame buffer and drives a 1/16-scan HUB75 LED panel using 8-plane binary-code modulation (BCM). Owns `actual_buffer`, the index of the buffer currently displayed, and flips it only at a frame boundary when the writer's `selected_buffer` differs.

## Interface
- `COLS`, default 5, log2 of the column count (32 columns).
- `BASE_CYCLES`, default 2, OE-low cycles for bit plane 0; plane k shows for `BASE_CYCLES << k` cycles.
- `clk` in 1: system clock, single domain.
- `rst` in 1: reset, synchronous, active-low.
- `rd_addr` out 5+COLS: frame-buffer read address {row[4:0], col[COLS-1:0]}.
- `rd_data` in 24: pixel {blue[7:0], green[7:0], red[7:0]}, valid exactly 1 cycle after `rd_addr`.
- `selected_buffer` in 1: buffer the writer has finished and requests for display.
- `actual_buffer` out 1: buffer being displayed; the memory uses it as the read-bank select.
- `r0`,`g0`,`b0` out 1 each: upper-half data (rows 0–15).
- `r1`,`g1`,`b1` out 1 each: lower-half data (rows 16–31).
- `row_sel` out 4: HUB75 A–D row address.
- `panel_clk` out 1: shift clock, data sampled on rising edge.
- `lat` out 1: latch strobe, active-high.
- `oe_n` out 1: output enable, active-low.

## Operation
- Counters: `row` 0..15, `col` 0..2^COLS−1, `plane` 0..7, `show_cnt` wide enough for `BASE_CYCLES<<7`.
- States: FETCH_TOP, FETCH_BOT, SHIFT_LO, SHIFT_HI, LATCH, SHOW.
- FETCH_TOP: `rd_addr={0,row,col}`, then FETCH_BOT.
- FETCH_BOT: `rd_addr={1,row,col}`, capture `rd_data` as top pixel, then SHIFT_LO.
- SHIFT_LO: capture bottom pixel. Drive `r0/g0/b0` = bit `plane` of top red/green/blue and `r1/g1/b1` = the same bit of bottom. `panel_clk=0`. Then SHIFT_HI.
- SHIFT_HI: `panel_clk=1`, data held. If col is last: col←0, go to LATCH. Otherwise col+1, go to FETCH_TOP.
- LATCH (1 cycle): `oe_n=1`, `lat=1`, `row_sel←row`, `show_cnt←BASE_CYCLES<<plane`. Then SHOW.
- SHOW: `oe_n=0`, `show_cnt` decrements. On the cycle `show_cnt` reaches 1: `oe_n` returns to 1 the next cycle, and
  - plane+1;
  - if plane was 7: plane←0, row+1;
  - if row was 15: row←0 and frame end.
  - Then FETCH_TOP.
- Frame end: if `selected_buffer != actual_buffer`, `actual_buffer←selected_buffer` in the same cycle as the transition to FETCH_TOP. The first fetch of the new frame reads the new bank.
- `selected_buffer` changes at any other time are ignored until the next frame end. Multiple toggles within one frame resolve to the value sampled at frame end.
- `oe_n` is high in every state except SHOW. `lat` is high only in LATCH. Row and data never change while `oe_n=0`.

## Timing
- Reset (`rst=0` at a clk edge), from any state including mid-shift or mid-SHOW:
  - next cycle: state FETCH_TOP, row=col=plane=0;
  - `oe_n=1`, `lat=0`, `panel_clk=0`, all color outputs 0, `row_sel=0`, `rd_addr=0`, `actual_buffer=0`.
- Per column: 4 cycles. Per plane: 4·2^COLS + 1 + `BASE_CYCLES<<plane` cycles.
- Defaults, one plane: 128 + 1 + 2·2^k cycles. One row (8 planes): 8·129 + 510 = 1542 cycles. One frame: 16·1542 = 24672 cycles.
- Read-data latency is fixed at 1. No stall or handshake on the memory side.
- Width rules:
  - `show_cnt` width = clog2(BASE_CYCLES·128)+1.
  - `col` wraps naturally at 2^COLS−1.
  - `row` and `plane` compare explicitly against 15 and 7.

## Structure
- Shared package `led_panel_pkg`:
  - scanner state enum;
  - pixel field offsets (RED=0, GREEN=8, BLUE=16) and pixel width 24;
  - PANEL_ROWS=32, SCAN_ROWS=16, PLANES=8.
  - The dimmer and the frame-buffer memory use the same package.
- Sub-module `bcm_timer`: loads `BASE_CYCLES<<plane` on a start pulse, counts down, and drives `oe_n` and a done pulse. The scanner FSM owns fetch, shift and latch.

## Test plan
- Reset: hold `rst=0` 3 cycles, release → `oe_n=1`, `lat=0`, `actual_buffer=0`, first `rd_addr=0x000` then `0x200`, `panel_clk` rises on the 4th cycle.
- Single pixel: bank 0 pixel(row 0, col 0)=0x0000FF, all others 0 → `r0=1` on col 0 for planes 0–7, all other color bits 0.
  - Check SHOW lengths 2,4,8,…,256 cycles.
- Bottom half: pixel(row 17, col 31)=0x00FF00 → `g1=1` only on the last shift of every plane while `row_sel=1`.
- Buffer swap: set `selected_buffer=1` mid-frame → `actual_buffer` stays 0 until exactly 24672 cycles after reset, then becomes 1, and the next `rd_addr` reads bank 1.
  - Toggling 1→0 within the same frame → no swap.
- Reset mid-SHOW at plane 5, row 9 → next cycle `oe_n=1`, counters 0, scan restarts at `rd_addr=0`.
- Invariants over 2 full frames: `lat` pulses 256 times; `row_sel` and color outputs never change while `oe_n=0`.

Source files
------------

// File: rtl/led_panel_pkg.sv
// rtl/led_panel_pkg.sv - shared types and constants for the LED panel frame path
package led_panel_pkg;

    typedef enum logic [2:0] {
        FETCH_TOP,
        FETCH_BOT,
        SHIFT_LO,
        SHIFT_HI,
        LATCH,
        SHOW
    } scan_state_t;

    localparam int PIXEL_W    = 24;
    localparam int RED_OFS    = 0;
    localparam int GREEN_OFS  = 8;
    localparam int BLUE_OFS   = 16;

    localparam int PANEL_ROWS = 32;
    localparam int SCAN_ROWS  = 16;
    localparam int PLANES     = 8;

    // Selects one BCM bit plane of a pixel, returned as {blue, green, red}.
    function automatic logic [2:0] pixel_bits(input logic [PIXEL_W-1:0] px,
                                              input logic [2:0]         plane);
        logic [PIXEL_W-1:0] s;
        s = px >> plane;
        return {s[BLUE_OFS], s[GREEN_OFS], s[RED_OFS]};
    endfunction

endpackage

// File: rtl/panel_scanner_bcm_timer.sv
// rtl/panel_scanner_bcm_timer.sv - per-plane output-enable timer for BCM display
module bcm_timer
    import led_panel_pkg::*;
#(
    parameter  int BASE_CYCLES = 2,
    localparam int CNT_W       = $clog2(BASE_CYCLES * 128) + 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] plane,
    output logic       oe_n,
    output logic       done
);

    logic [CNT_W-1:0] show_cnt;
    logic             running;

    // The last lit cycle is the one where the count sits at 1.
    assign done = running && (show_cnt == CNT_W'(1));
    assign oe_n = ~running;

    // Load the plane weight on start, then count the lit cycles down.
    always_ff @(posedge clk) begin
        if (!rst) begin
            show_cnt <= '0;
            running  <= 1'b0;
        end else if (start) begin
            show_cnt <= CNT_W'(BASE_CYCLES) << plane;
            running  <= 1'b1;
        end else if (running) begin
            show_cnt <= show_cnt - CNT_W'(1);
            if (show_cnt == CNT_W'(1)) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/panel_scanner.sv
// rtl/panel_scanner.sv - HUB75 1/16-scan BCM scanner reading a double-buffered frame
module panel_scanner
    import led_panel_pkg::*;
#(
    parameter int COLS        = 5,
    parameter int BASE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic [4+COLS:0]   rd_addr,
    input  logic [23:0]       rd_data,
    input  logic              selected_buffer,
    output logic              actual_buffer,
    output logic              r0,
    output logic              g0,
    output logic              b0,
    output logic              r1,
    output logic              g1,
    output logic              b1,
    output logic [3:0]        row_sel,
    output logic              panel_clk,
    output logic              lat,
    output logic              oe_n
);

    scan_state_t      state;
    scan_state_t      state_nxt;

    logic [3:0]       row;
    logic [COLS-1:0]  col;
    logic [2:0]       plane;
    logic [23:0]      top_px;
    logic [5:0]       color_q;
    logic [5:0]       color_live;
    logic             timer_start;
    logic             timer_done;
    logic             last_col;
    logic             last_plane;
    logic             last_row;

    assign last_col   = &col;
    assign last_plane = (plane == 3'd7);
    assign last_row   = (row == 4'd15);

    // Top half in FETCH_TOP, bottom half (address MSB set) in FETCH_BOT.
    assign rd_addr = {state == FETCH_BOT, row, col};

    // Bottom pixel arrives in SHIFT_LO; show it live then and hold it afterwards.
    assign color_live = {pixel_bits(rd_data, plane), pixel_bits(top_px, plane)};
    assign {b1, g1, r1, b0, g0, r0} = (state == SHIFT_LO) ? color_live : color_q;

    bcm_timer #(
        .BASE_CYCLES (BASE_CYCLES)
    ) u_bcm_timer (
        .clk   (clk),
        .rst   (rst),
        .start (timer_start),
        .plane (plane),
        .oe_n  (oe_n),
        .done  (timer_done)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= FETCH_TOP;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and strobe decode for fetch, shift, latch and show.
    always_comb begin
        state_nxt   = state;
        timer_start = 1'b0;
        lat         = 1'b0;
        panel_clk   = 1'b0;
        case (state)
            FETCH_TOP: state_nxt = FETCH_BOT;
            FETCH_BOT: state_nxt = SHIFT_LO;
            SHIFT_LO:  state_nxt = SHIFT_HI;
            SHIFT_HI: begin
                panel_clk = 1'b1;
                state_nxt = last_col ? LATCH : FETCH_TOP;
            end
            LATCH: begin
                lat         = 1'b1;
                timer_start = 1'b1;
                state_nxt   = SHOW;
            end
            SHOW: begin
                if (timer_done) begin
                    state_nxt = FETCH_TOP;
                end
            end
            default: state_nxt = FETCH_TOP;
        endcase
    end

    // Scan counters, pixel capture, row latch and frame-boundary bank flip.
    always_ff @(posedge clk) begin
        if (!rst) begin
            row           <= '0;
            col           <= '0;
            plane         <= '0;
            top_px        <= '0;
            color_q       <= '0;
            row_sel       <= '0;
            actual_buffer <= 1'b0;
        end else begin
            case (state)
                FETCH_BOT: top_px  <= rd_data;
                SHIFT_LO:  color_q <= color_live;
                SHIFT_HI:  col     <= col + 1'b1;
                LATCH:     row_sel <= row;
                SHOW: begin
                    if (timer_done) begin
                        plane <= plane + 3'd1;
                        if (last_plane) begin
                            plane <= 3'd0;
                            row   <= last_row ? 4'd0 : row + 4'd1;
                            if (last_row && (selected_buffer != actual_buffer)) begin
                                actual_buffer <= selected_buffer;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_panel_scanner.sv
// tb/tb_panel_scanner.sv - scoreboard bench for panel_scanner
module tb_panel_scanner;

    localparam int COLS  = 5;
    localparam int BASE  = 2;
    localparam int NCOL  = 32;
    localparam int FRAME = 24672;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [23:0] rd_data;
    logic        selected_buffer;
    logic        actual_buffer;
    logic        r0, g0, b0, r1, g1, b1;
    logic [3:0]  row_sel;
    logic        panel_clk, lat, oe_n;

    always #5 clk = ~clk;

    panel_scanner #(.COLS(COLS), .BASE_CYCLES(BASE)) dut (
        .clk             (clk),
        .rst             (rst),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .selected_buffer (selected_buffer),
        .actual_buffer   (actual_buffer),
        .r0              (r0),
        .g0              (g0),
        .b0              (b0),
        .r1              (r1),
        .g1              (g1),
        .b1              (b1),
        .row_sel         (row_sel),
        .panel_clk       (panel_clk),
        .lat             (lat),
        .oe_n            (oe_n)
    );

    logic [23:0] mem [0:1][0:1023];

    // Frame memory: one-cycle read latency, bank chosen by actual_buffer.
    always @(posedge clk) rd_data <= mem[actual_buffer][rd_addr];

    typedef struct {
        bit       is_latch;
        bit [5:0] bits;
        int       row;
        int       len;
    } ev_t;

    ev_t exp_q[$];
    int  vectors = 0;
    int  miscompares = 0;
    int  lat_count = 0;
    int  t;
    int  sel_model;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0d)", name, act, exp, t);
        end
    endtask

    // Expected panel traffic for a frame: per row, per plane, 32 shifts then one latch.
    task automatic push_frame(input int bank, input int rows);
        ev_t e;
        logic [23:0] top, bot;
        for (int r = 0; r < rows; r++) begin
            for (int p = 0; p < 8; p++) begin
                for (int c = 0; c < NCOL; c++) begin
                    top = mem[bank][r * NCOL + c];
                    bot = mem[bank][(r + 16) * NCOL + c];
                    e.is_latch = 1'b0;
                    e.bits = {bot[16 + p], bot[8 + p], bot[p], top[16 + p], top[8 + p], top[p]};
                    e.row = 0;
                    e.len = 0;
                    exp_q.push_back(e);
                end
                e.is_latch = 1'b1;
                e.bits = '0;
                e.row = r;
                e.len = BASE << p;
                exp_q.push_back(e);
            end
        end
    endtask

    // Monitor: pops on every panel_clk rise and latch, times each lit period.
    ev_t      cur;
    bit       in_show = 0;
    bit       prev_clk = 0;
    int       show_len = 0;
    bit       stable_err = 0;
    logic [9:0] snap;
    always @(negedge clk) begin
        if (!rst) begin
            in_show  = 0;
            prev_clk = 0;
            show_len = 0;
        end else begin
            if (panel_clk && !prev_clk) begin
                if (exp_q.size() == 0) begin
                    chk("shift_queue_empty", 1, 0);
                end else begin
                    cur = exp_q.pop_front();
                    chk("shift_kind", 0, int'(cur.is_latch));
                    chk("shift_colors", int'({b1, g1, r1, b0, g0, r0}), int'(cur.bits));
                end
            end
            if (lat) begin
                lat_count++;
                if (exp_q.size() == 0) begin
                    chk("latch_queue_empty", 1, 0);
                end else begin
                    cur = exp_q.pop_front();
                    chk("latch_kind", 1, int'(cur.is_latch));
                    in_show    = 1;
                    show_len   = 0;
                    stable_err = 0;
                end
            end
            if (!oe_n) begin
                if (show_len == 0) begin
                    snap = {row_sel, b1, g1, r1, b0, g0, r0};
                end else if (snap != {row_sel, b1, g1, r1, b0, g0, r0}) begin
                    stable_err = 1;
                end
                show_len++;
            end else if (in_show && show_len > 0) begin
                chk("show_len", show_len, cur.len);
                chk("show_row_sel", int'(snap[9:6]), cur.row);
                chk("show_stable", int'(stable_err), 0);
                in_show = 0;
            end
            prev_clk = panel_clk;
        end
    end

    task automatic run_until(input int target);
        while (t < target) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic set_sel(input logic v);
        @(posedge clk);
        #1 selected_buffer = v;
    endtask

    int a_t, b_t, lat_base;

    initial begin
        rst = 1'b0;
        selected_buffer = 1'b0;
        sel_model = 0;
        t = 0;
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 1024; a++)
                mem[b][a] = 24'($urandom());
        mem[0][0]             = 24'h0000FF;
        mem[0][17 * NCOL + 31] = 24'h00FF00;

        // Run 1: 3-cycle reset, partial frame, reset in the middle of a SHOW.
        push_frame(0, 10);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        t = 0;
        chk("rst_oe_n", int'(oe_n), 1);
        chk("rst_lat", int'(lat), 0);
        chk("rst_actual", int'(actual_buffer), 0);
        chk("first_rd_addr", int'(rd_addr), 'h000);
        run_until(1);
        chk("second_rd_addr", int'(rd_addr), 'h200);
        run_until(2);
        chk("pclk_low_c3", int'(panel_clk), 0);
        run_until(3);
        chk("pclk_high_c4", int'(panel_clk), 1);

        a_t = $urandom_range(100, 4000);
        run_until(a_t);
        set_sel(1'b1);
        b_t = $urandom_range(5000, 12000);
        run_until(b_t);
        set_sel(1'b0);

        run_until(9 * 1542 + 707 + 129 + 10);
        chk("midshow_oe_n", int'(oe_n), 0);
        chk("midshow_row_sel", int'(row_sel), 9);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst2_oe_n", int'(oe_n), 1);
        chk("rst2_lat", int'(lat), 0);
        chk("rst2_pclk", int'(panel_clk), 0);
        chk("rst2_colors", int'({b1, g1, r1, b0, g0, r0}), 0);
        chk("rst2_row_sel", int'(row_sel), 0);
        chk("rst2_rd_addr", int'(rd_addr), 0);
        chk("rst2_actual", int'(actual_buffer), 0);
        exp_q.delete();

        // Run 2: two full frames with a bank swap, then a 1->0->1 toggle.
        push_frame(0, 16);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        t = 0;
        lat_base = lat_count;
        chk("run2_rd_addr0", int'(rd_addr), 0);
        run_until(1);
        chk("run2_rd_addr1", int'(rd_addr), 'h200);

        a_t = $urandom_range(200, 20000);
        run_until(a_t);
        set_sel(1'b1);
        sel_model = 1;
        run_until(24000);
        push_frame(sel_model, 16);
        run_until(FRAME - 1);
        chk("swap_before", int'(actual_buffer), 0);
        run_until(FRAME);
        chk("swap_after", int'(actual_buffer), 1);
        chk("swap_rd_addr", int'(rd_addr), 0);

        a_t = $urandom_range(FRAME + 200, 35000);
        run_until(a_t);
        set_sel(1'b0);
        b_t = $urandom_range(36000, 48000);
        run_until(b_t);
        set_sel(1'b1);
        run_until(48700);
        push_frame(sel_model, 16);
        run_until(2 * FRAME - 1);
        chk("lat_pulses_2frames", lat_count - lat_base, 256);
        chk("noswap_before", int'(actual_buffer), 1);
        run_until(2 * FRAME);
        chk("noswap_after", int'(actual_buffer), 1);
        chk("frame2_rd_addr", int'(rd_addr), 0);
        run_until(2 * FRAME + 300);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
